// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the washing-cycle phase timer: FSM state
// encoding, clk_freq select codes and the per-selection tick divisor.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FREQ_X1 = 2'd0;
  localparam logic [1:0] FREQ_X2 = 2'd1;
  localparam logic [1:0] FREQ_X4 = 2'd2;
  localparam logic [1:0] FREQ_X8 = 2'd3;

  // Input clocks per countdown tick for one clk_freq selection.
  function automatic int div_of(input int base_hz, input int tick_hz, input logic [1:0] sel);
    return (base_hz << sel) / tick_hz;
  endfunction

endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// Prescaler for the phase timer: counts 0..last while enabled and emits a
// one-cycle tick on wrap. The terminal value is latched on load.
module tick_prescaler #(
  parameter int CNT_W = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] last_in,
  input  logic             enable,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_q;

  assign tick = enable && !clear && (cnt == last_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (load) begin
        last_q <= last_in;
      end
      if (clear) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= (cnt == last_q) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Washing-cycle phase timer: runtime duration table, selectable-clock seconds
// tick, countdown with pause/abort. Optional near-end warning: PHASE_TIMER_WARN_EN.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int BASE_HZ    = 1_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_PHASES = 8,
  parameter int SEC_W      = 16,
  parameter int WARN_SEC   = 10,
  localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       clk_freq,
  input  logic             cfg_we,
  input  logic [PH_W-1:0]  cfg_addr,
  input  logic [SEC_W-1:0] cfg_data,
  input  logic             start,
  input  logic [PH_W-1:0]  phase,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic [PH_W-1:0]  active_phase,
  output logic [SEC_W-1:0] remaining,
  output logic             click,
  output logic             warn
);

  localparam int PS_RAW = $clog2(8 * BASE_HZ / TICK_HZ);
  localparam int PS_W   = (PS_RAW > 0) ? PS_RAW : 1;

  localparam int D1 = div_of(BASE_HZ, TICK_HZ, FREQ_X1);
  localparam int D2 = div_of(BASE_HZ, TICK_HZ, FREQ_X2);
  localparam int D4 = div_of(BASE_HZ, TICK_HZ, FREQ_X4);
  localparam int D8 = div_of(BASE_HZ, TICK_HZ, FREQ_X8);

  localparam logic [PS_W-1:0] LAST1 = PS_W'(D1 - 1);
  localparam logic [PS_W-1:0] LAST2 = PS_W'(D2 - 1);
  localparam logic [PS_W-1:0] LAST4 = PS_W'(D4 - 1);
  localparam logic [PS_W-1:0] LAST8 = PS_W'(D8 - 1);

  // The slowest selection has the smallest divisor; if it is zero the tick rate is unreachable.
  if (D1 < 1) begin : g_bad_div
    $error("phase_timer: TICK_HZ exceeds BASE_HZ, tick divisor is zero");
  end
  if (WARN_SEC < 0) begin : g_bad_warn
    $error("phase_timer: WARN_SEC must not be negative");
  end

  state_t           state;
  logic [SEC_W-1:0] dur_tbl [NUM_PHASES];
  logic [SEC_W-1:0] tbl_rd;
  logic [PS_W-1:0]  div_last_sel;
  logic             start_acc;
  logic             counting;
  logic             tick;

  assign tbl_rd    = (int'(phase) < NUM_PHASES) ? dur_tbl[phase] : '0;
  assign start_acc = start && !abort && ((state == IDLE) || (state == DONE));
  assign counting  = !abort && !pause && ((state == RUN) || (state == PAUSE));

  always_comb begin
    div_last_sel = LAST1;
    case (clk_freq)
      FREQ_X1: div_last_sel = LAST1;
      FREQ_X2: div_last_sel = LAST2;
      FREQ_X4: div_last_sel = LAST4;
      FREQ_X8: div_last_sel = LAST8;
    endcase
  end

  // Duration table; a write lands on the edge, so a same-cycle start reads the old entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur_tbl[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_PHASES)) begin
      dur_tbl[cfg_addr] <= cfg_data;
    end
  end

  tick_prescaler #(
    .CNT_W (PS_W)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (abort || start_acc),
    .load    (start_acc),
    .last_in (div_last_sel),
    .enable  (counting),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      active_phase <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      click        <= 1'b0;
    end else begin
      click <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        remaining <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              active_phase <= phase;
              remaining    <= tbl_rd;
              state        <= RUN;
              busy         <= 1'b1;
            end
          end
          RUN, PAUSE: begin
            if ((state == RUN) && (remaining == '0)) begin
              state <= DONE;
              busy  <= 1'b0;
              click <= 1'b1;
            end else begin
              state <= pause ? PAUSE : RUN;
              if (tick && (remaining != '0)) begin
                remaining <= remaining - 1'b1;
                if (remaining == SEC_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  click <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PHASE_TIMER_WARN_EN
  function automatic logic near_end(input logic [SEC_W-1:0] r);
    return (r != '0) && (r <= SEC_W'(WARN_SEC));
  endfunction

  logic warn_q;

  // Tracks the value remaining takes on the same edge, so warn never lags the display.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else if (abort) begin
      warn_q <= 1'b0;
    end else if (start_acc) begin
      warn_q <= near_end(tbl_rd);
    end else if ((state == RUN) && (remaining == '0)) begin
      warn_q <= 1'b0;
    end else if (tick && (remaining != '0)) begin
      warn_q <= near_end(remaining - 1'b1);
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: doc/phase_timer.md
# phase_timer

Parametrised washing-cycle phase timer: holds a programmable duration table (seconds per phase), derives a seconds tick from the selected input clock frequency, and counts down the active phase with pause/resume and abort. It sits between the washing-machine controller FSM, which issues `start` and `phase` and consumes `click`, and the configuration interface that writes phase durations. It replaces fixed-duration, fixed-frequency phase timing with a runtime-loadable table and a visible remaining-time output.

## Interface
- `BASE_HZ`, 1_000_000: clock frequency at `clk_freq`=0. Selection n gives BASE_HZ<<n.
- `TICK_HZ`, 1: countdown tick rate. Set it higher in simulation to shorten runs.
- `NUM_PHASES`, 8: number of duration table entries. PH_W = max(1, $clog2(NUM_PHASES)).
- `SEC_W`, 16: width of the duration and remaining-time fields.
- `WARN_SEC`, 10: near-end warning threshold, used only with the warn feature.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk_freq`  in  2  frequency select. 0=1×, 1=2×, 2=4×, 3=8× BASE_HZ.
- `cfg_we`  in  1  duration table write strobe.
- `cfg_addr`  in  PH_W  table index.
- `cfg_data`  in  SEC_W  duration in seconds.
- `start`  in  1  one-cycle request to start timing `phase`.
- `phase`  in  PH_W  phase to time. Sampled together with `start`.
- `pause`  in  1  level. While high, counting is frozen.
- `abort`  in  1  one-cycle cancel request.
- `busy`  out  1  high in RUN or PAUSE.
- `active_phase`  out  PH_W  phase latched at start.
- `remaining`  out  SEC_W  seconds left in the active phase.
- `click`  out  1  one-cycle pulse when the phase expires.
- `warn`  out  1  high while `remaining` ≤ WARN_SEC and ≠0 in RUN/PAUSE.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Reset puts the block in IDLE. The table, `remaining`, `active_phase`, prescaler, `busy`, `click` and `warn` all reset to 0.
- A table write takes effect on the next edge. Writes are legal in any state.
- IDLE/DONE + `start`:
  - Latch `phase` into `active_phase`.
  - Load `remaining` = table[phase].
  - Latch the divisor D = (BASE_HZ<<clk_freq)/TICK_HZ.
  - Clear the prescaler and go to RUN.
- RUN + `pause`: go to PAUSE. The prescaler does not advance in that cycle.
- PAUSE + !`pause`: go to RUN. Counting resumes from the frozen prescaler value.
- RUN + !`pause`:
  - The prescaler counts 0..D-1.
  - On wrap, `remaining` decrements.
  - If the decrement reaches 0, go to DONE and pulse `click`.
- Zero-duration entry: RUN→DONE on the first RUN cycle, with `click` pulsed in that same transition.
- `abort` in any state:
  - Go to IDLE and set `remaining`=0 and the prescaler to 0.
  - No `click` is issued.
- Priority: `abort` > `start` > `pause`.
- `start` in RUN/PAUSE is ignored.
- Arithmetic and width rules:
  - D is computed at elaboration per selection. D must be ≥1; a D of 0 is an elaboration error.
  - The prescaler width is $clog2(8·BASE_HZ/TICK_HZ).
  - `remaining` never wraps below 0.

## Timing
- Start sampled at edge E0 with duration N≥1: `click` is high in the cycle after edge E0+N·D. That is N·D cycles of RUN, with paused cycles added to the count.
- `remaining` decrements at edges E0+k·D, for k=1..N.
- `busy` rises the cycle after E0 and falls in the same cycle `click` rises.
- `click` is registered and lasts exactly one cycle.
- Changing `clk_freq` mid-phase has no effect until the next start.
- A write to table[active_phase] during RUN does not alter `remaining`.
- `start` and a `cfg_we` to the same address in the same cycle: start loads the old value.
- `start` in DONE in the same cycle `click` is high is accepted.
- Reset mid-phase returns immediately (asynchronously) to the reset values. No `click` is issued.

## Configuration
- Macro `PHASE_TIMER_WARN_EN`.
- Defined: the `warn` comparator is present, with `warn` registered and updated alongside `remaining`.
- Undefined: `warn` is tied to 0, the comparator is omitted and WARN_SEC is ignored.

## Structure
- Package `phase_timer_pkg`:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - `clk_freq` encoding constants.
  - Divisor function div_of(base_hz, tick_hz, sel).
- Sub-module `tick_prescaler`:
  - Holds the prescaler counter with clear, enable and latched divisor.
  - Outputs a one-cycle `tick` on wrap.
- The top level holds the table, FSM, countdown and outputs.

## Test plan
Bench parameters: BASE_HZ=4, TICK_HZ=1, NUM_PHASES=4, SEC_W=8.
- Basic run: write table[2]=3, `clk_freq`=0, start phase 2. Expect `remaining` 3→2→1→0 at 4-cycle intervals, `click` 12 cycles after the start edge, `busy` low at `click`.
- Frequency select: same entry with `clk_freq`=3 (D=32). Expect `click` at 96 cycles. A `clk_freq` change mid-run leaves that at 96.
- Pause: start table[1]=2 and hold `pause` for 5 cycles after 3 RUN cycles. Expect `click` at 8+5=13 cycles and `remaining` frozen during the pause.
- Abort and ignored start: abort at cycle 6 of a 3 s phase gives IDLE, `remaining`=0 and no `click`. `start` during RUN leaves `active_phase` unchanged.
- Zero duration and write collision:
  - table[0]=0, start: `click` pulses one cycle after RUN entry.
  - Start with a simultaneous write of 5 to the same index: the countdown uses the old value, and the next start uses 5.
- With `PHASE_TIMER_WARN_EN` defined and WARN_SEC=2: `warn` rises when `remaining`=2 and falls at `click`. With the macro undefined, `warn` stays 0 throughout.
